mioc_mc: RTL

- Multi-channel memory/IO controller between the CPU data port and the data RAM plus IO peripherals.
- Decodes each CPU access as RAM, one of IO_CH IO channels, or error.
- Generates big-endian byte selects and lane-aligned write data.
- Inserts RAM wait states, waits on per-channel IO acknowledge with a timeout, and returns a one-cycle ready/err response so the CPU stalls for variable-latency accesses.

---
 rtl/mioc_mc_pkg.sv | 29 ++
 rtl/mioc_mc_if.sv | 33 +++
 rtl/mioc_mc_lane.sv | 57 +++++
 rtl/mioc_mc.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mioc_mc_pkg.sv
// mioc_mc_pkg
// Shared definitions for the memory/IO controller: CPU access size codes,
// controller state encoding, the default IO region base and the big-endian
// byte-lane select patterns (bit 3 = byte at address offset 0).
package mioc_mc_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RAM  = 2'b01,
    ST_IO   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFFF000;

  localparam logic [3:0] SEL_BYTE0 = 4'b1000;
  localparam logic [3:0] SEL_HALF0 = 4'b1100;
  localparam logic [3:0] SEL_HALF1 = 4'b0011;
  localparam logic [3:0] SEL_WORD  = 4'b1111;
  localparam logic [3:0] SEL_NONE  = 4'b0000;

endpackage

// File: rtl/mioc_mc_if.sv
// mioc_mc_if
// CPU data-port bundle between the CPU (master) and the controller (slave).
//   req_i   : access request, held with its operands until ready_o
//   we_i    : 1 = write
//   size_i  : 00 byte, 01 half, 10 word, 11 reserved
//   addr_i  : byte address
//   wdata_i : right-justified write data
//   rdata_o : right-justified, zero-extended read data
//   ready_o : one-cycle completion pulse
//   err_o   : access failed, valid with ready_o
interface mioc_mc_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              ready_o;
  logic              err_o;

  modport master (
    output req_i, we_i, size_i, addr_i, wdata_i,
    input  rdata_o, ready_o, err_o
  );

  modport slave (
    input  req_i, we_i, size_i, addr_i, wdata_i,
    output rdata_o, ready_o, err_o
  );
endinterface

// File: rtl/mioc_mc_lane.sv
// mioc_mc_lane
// Combinational big-endian lane logic for a 32-bit bus.
//   size       : access size code
//   offset     : address bits [1:0]
//   wdata      : right-justified write data
//   lane_rdata : full bus word as returned by RAM or an IO channel
//   sel        : byte-lane select, bit 3 = offset 0 (0000 for reserved size)
//   lane_wdata : write data replicated onto every lane of its size
//   rdata      : selected lanes shifted to bit 0, zero-extended
module mioc_mc_lane
  import mioc_mc_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] lane_rdata,
  output logic [3:0]  sel,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata
);

  // Replicating the write data means the selected lanes always carry the
  // operand regardless of offset, so no write-side shifter is needed.
  always_comb begin
    sel        = SEL_NONE;
    lane_wdata = '0;
    rdata      = '0;
    case (size)
      SIZE_BYTE: begin
        sel        = SEL_BYTE0 >> offset;
        lane_wdata = {4{wdata[7:0]}};
        case (offset)
          2'd0:    rdata = {24'b0, lane_rdata[31:24]};
          2'd1:    rdata = {24'b0, lane_rdata[23:16]};
          2'd2:    rdata = {24'b0, lane_rdata[15:8]};
          default: rdata = {24'b0, lane_rdata[7:0]};
        endcase
      end
      SIZE_HALF: begin
        sel        = offset[1] ? SEL_HALF1 : SEL_HALF0;
        lane_wdata = {2{wdata[15:0]}};
        rdata      = offset[1] ? {16'b0, lane_rdata[15:0]} : {16'b0, lane_rdata[31:16]};
      end
      SIZE_WORD: begin
        sel        = SEL_WORD;
        lane_wdata = wdata;
        rdata      = lane_rdata;
      end
      default: begin
        sel        = SEL_NONE;
        lane_wdata = '0;
        rdata      = '0;
      end
    endcase
  end

endmodule

// File: rtl/mioc_mc.sv
// mioc_mc
// Multi-channel memory/IO controller between the CPU data port and the data
// RAM plus IO_CH word-sized IO channels.
//   clk, rst      : clock, asynchronous active-low reset
//   cpu           : CPU data port (mioc_mc_if.slave)
//   ram_*         : word-aligned RAM address, lane data, byte selects, we, ce
//   io_addr_o     : word-aligned IO address
//   io_data_o/i   : lane write data / per-channel read data (ch at ch*DATA_W)
//   io_ack_i      : per-channel acknowledge
//   io_we_o/ce_o  : IO write enable / one-hot channel enable
// Each access goes IDLE -> (RAM | IO | straight to RESP on decode error)
// -> RESP, where ready_o pulses for one cycle.
module mioc_mc
  import mioc_mc_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                IO_CH    = 4,
  parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(IO_BASE_DEFAULT),
  parameter int                RAM_WAIT = 0,
  parameter int                TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  mioc_mc_if.slave                cpu,
  output logic [ADDR_W-1:0]       ram_addr_o,
  output logic [DATA_W-1:0]       ram_data_o,
  input  logic [DATA_W-1:0]       ram_data_i,
  output logic                    ram_we_o,
  output logic [3:0]              ram_sel_o,
  output logic                    ram_ce_o,
  output logic [ADDR_W-1:0]       io_addr_o,
  output logic [DATA_W-1:0]       io_data_o,
  input  logic [IO_CH*DATA_W-1:0] io_data_i,
  input  logic [IO_CH-1:0]        io_ack_i,
  output logic                    io_we_o,
  output logic [IO_CH-1:0]        io_ce_o
);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic                we_q, err_q;
  size_e               size_q;
  logic [2:0]          ch_q;
  logic [7:0]          cnt;

  logic                dec_io, dec_err;
  logic                io_busy, io_ack, ram_last, io_tmo;
  logic [IO_CH-1:0]    ch_hot;
  logic [DATA_W-1:0]   io_rd, rd_src, rd_ext, lane_wdata;
  logic [3:0]          wr_sel;
  logic [3:0]          rd_sel_unused;
  logic [DATA_W-1:0]   rd_wdata_unused, wr_rdata_unused;

  // Decode of the raw CPU request; only consulted while IDLE.
  always_comb begin
    dec_io  = (cpu.addr_i[ADDR_W-1:12] == IO_BASE[ADDR_W-1:12]);
    dec_err = 1'b0;
    case (size_e'(cpu.size_i))
      SIZE_HALF: dec_err = cpu.addr_i[0];
      SIZE_WORD: dec_err = (cpu.addr_i[1:0] != 2'b00);
      SIZE_RSVD: dec_err = 1'b1;
      default:   dec_err = 1'b0;
    endcase
    if (dec_io && (cpu.addr_i[11:2] >= 10'(IO_CH)))
      dec_err = 1'b1;
  end

  // Channel one-hot and read-data mux from the latched channel index;
  // acks from channels other than the addressed one are masked off here.
  always_comb begin
    ch_hot = '0;
    io_rd  = '0;
    for (int i = 0; i < IO_CH; i++) begin
      if (ch_q == 3'(i)) begin
        ch_hot[i] = 1'b1;
        io_rd     = io_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign io_ack   = |(io_ack_i & ch_hot);
  assign ram_last = (cnt == 8'(RAM_WAIT));
  assign io_tmo   = (cnt == 8'(TIMEOUT - 1));
  assign rd_src   = (state == ST_IO) ? io_rd : ram_data_i;

  mioc_mc_lane u_wr_lane (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .lane_rdata ('0),
    .sel        (wr_sel),
    .lane_wdata (lane_wdata),
    .rdata      (wr_rdata_unused)
  );

  mioc_mc_lane u_rd_lane (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .wdata      ('0),
    .lane_rdata (rd_src),
    .sel        (rd_sel_unused),
    .lane_wdata (rd_wdata_unused),
    .rdata      (rd_ext)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state and strobes; everything is derived from the state so that an
  // asynchronous reset drops every enable and ready_o at once.
  always_comb begin
    state_nxt   = state;
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_sel_o   = SEL_NONE;
    io_busy     = 1'b0;
    io_we_o     = 1'b0;
    cpu.ready_o = 1'b0;
    cpu.err_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu.req_i) begin
          if (dec_err)     state_nxt = ST_RESP;
          else if (dec_io) state_nxt = ST_IO;
          else             state_nxt = ST_RAM;
        end
      end
      ST_RAM: begin
        ram_ce_o  = 1'b1;
        ram_we_o  = we_q;
        ram_sel_o = wr_sel;
        if (ram_last) state_nxt = ST_RESP;
      end
      ST_IO: begin
        io_busy = 1'b1;
        io_we_o = we_q;
        if (io_ack || io_tmo) state_nxt = ST_RESP;
      end
      default: begin
        cpu.ready_o = 1'b1;
        cpu.err_o   = err_q;
        state_nxt   = ST_IDLE;
      end
    endcase
  end

  // Operand latch, wait/timeout counter and response register. rdata_q only
  // changes on the way into RESP so it holds until the next ready_o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_BYTE;
      ch_q    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu.req_i) begin
            addr_q  <= cpu.addr_i;
            wdata_q <= cpu.wdata_i;
            we_q    <= cpu.we_i;
            size_q  <= size_e'(cpu.size_i);
            ch_q    <= cpu.addr_i[4:2];
            cnt     <= '0;
            err_q   <= dec_err;
            if (dec_err) rdata_q <= '0;
          end
        end
        ST_RAM: begin
          cnt <= cnt + 8'd1;
          if (ram_last) rdata_q <= we_q ? '0 : rd_ext;
        end
        ST_IO: begin
          cnt <= cnt + 8'd1;
          if (io_ack) begin
            rdata_q <= we_q ? '0 : rd_ext;
          end else if (io_tmo) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu.rdata_o = rdata_q;
  assign ram_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign io_addr_o   = {addr_q[ADDR_W-1:2], 2'b00};
  assign ram_data_o  = lane_wdata;
  assign io_data_o   = lane_wdata;
  assign io_ce_o     = io_busy ? ch_hot : '0;

endmodule
